l4_mux8_sequencer: RTL

//  - Upstream controller for the 8:1 word mux: drives its 3-bit select, captures the selected word.
//  - On start, scans slots 0..7 in order and emits each captured word on a valid/ready stream.
//  - Sits between the mux and the downstream serial/display consumer; turns a parallel 8-word bank into a word stream.

---
 rtl/l4_seq_pkg.sv | 18 +
 rtl/l4_slot_picker.sv | 40 ++++
 rtl/l4_mux8_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/l4_seq_pkg.sv
// l4_seq_pkg: shared constants for the 8:1 mux scan sequencer.
//   - scan state encoding (IDLE / SEL / OUT)
//   - slot count, select width, first/last slot of an unmasked scan
package l4_seq_pkg;

    localparam int NSLOTS = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] FIRST_SLOT = 3'd0;
    localparam logic [SEL_W-1:0] LAST_SLOT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_OUT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/l4_slot_picker.sv
// l4_slot_picker: combinational slot search over an 8-bit slot mask.
// Only instantiated when L4_SEQ_MASK_EN is defined.
// Ports:
//   mask     in  [7:0]  enabled slots
//   from_idx in  [2:0]  first candidate slot
//   next_idx out [2:0]  lowest enabled slot >= from_idx (0 when none)
//   found    out        an enabled slot >= from_idx exists
//   is_last  out        next_idx is the highest enabled slot
module l4_slot_picker
    import l4_seq_pkg::*;
(
    input  logic [NSLOTS-1:0] mask,
    input  logic [SEL_W-1:0]  from_idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              found,
    output logic              is_last
);

    always_comb begin
        next_idx = FIRST_SLOT;
        found    = 1'b0;
        is_last  = 1'b0;
        // Walk downwards so the lowest qualifying slot wins.
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) >= from_idx)) begin
                next_idx = SEL_W'(i);
                found    = 1'b1;
            end
        end
        if (found) begin
            is_last = 1'b1;
            for (int i = 0; i < NSLOTS; i++) begin
                if (mask[i] && (SEL_W'(i) > next_idx)) begin
                    is_last = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/l4_mux8_sequencer.sv
// l4_mux8_sequencer: drives the 3-bit select of an external 8:1 word mux,
// captures each selected word and emits it on a valid/ready stream.
// Optional feature: define L4_SEQ_MASK_EN to add slot_mask (sampled at start);
// slots whose mask bit is 0 are skipped.
// Ports:
//   clk, reset            clock, async active-high reset
//   start                 begin a scan (IDLE only)
//   abort                 synchronous return to IDLE
//   sel                   select to the mux (also the scan index)
//   mux_y                 mux output, combinational from sel
//   out_data/out_slot     captured word and its slot
//   out_valid/out_ready   stream handshake
//   busy                  not IDLE
//   done                  one-cycle pulse after the final word of a scan is accepted
//   slot_mask             (L4_SEQ_MASK_EN only) enabled slots
//
// state | meaning
// IDLE  | waiting for start
// SEL   | sel driven for one cycle, word captured at cycle end
// OUT   | out_valid high, holding word until accepted
module l4_mux8_sequencer
    import l4_seq_pkg::*;
#(
    parameter int NBITS        = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    input  logic [NBITS-1:0]  mux_y,
    output logic [NBITS-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_slot,
    output logic              busy,
    output logic              done
`ifdef L4_SEQ_MASK_EN
    ,
    input  logic [NSLOTS-1:0] slot_mask
`endif
);

    seq_state_t        state, state_d;
    logic [SEL_W-1:0]  sel_d, out_slot_d;
    logic [NBITS-1:0]  out_data_d;
    logic              out_valid_d, busy_d, done_d;

    logic [SEL_W-1:0]  first_slot, next_slot;
    logic              have_first, at_last;

`ifdef L4_SEQ_MASK_EN
    logic [NSLOTS-1:0] mask_q, mask_src;
    logic              found_next;

    // In IDLE the live port decides the first slot; afterwards the sampled copy.
    assign mask_src = (state == ST_IDLE) ? slot_mask : mask_q;

    l4_slot_picker u_pick_first (
        .mask     (mask_src),
        .from_idx (FIRST_SLOT),
        .next_idx (first_slot),
        .found    (have_first),
        .is_last  ()
    );

    l4_slot_picker u_pick_next (
        .mask     (mask_q),
        .from_idx (sel + 3'd1),
        .next_idx (next_slot),
        .found    (found_next),
        .is_last  ()
    );

    // sel+1 wraps at slot 7, so slot 7 is always the end of a pass.
    assign at_last = (sel == LAST_SLOT) || !found_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if ((state == ST_IDLE) && start && !abort) begin
            mask_q <= slot_mask;
        end
    end
`else
    assign first_slot = FIRST_SLOT;
    assign have_first = 1'b1;
    assign next_slot  = sel + 3'd1;
    assign at_last    = (sel == LAST_SLOT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_slot  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_slot  <= out_slot_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        sel_d       = sel;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_slot_d  = out_slot;
        done_d      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (have_first) begin
                        sel_d   = first_slot;
                        state_d = ST_SEL;
                    end else begin
                        // Empty scan: finishes immediately.
                        done_d  = 1'b1;
                        state_d = AUTO_RESTART ? ST_SEL : ST_IDLE;
                    end
                end
            end
            ST_SEL: begin
                if (have_first) begin
                    out_data_d  = mux_y;
                    out_slot_d  = sel;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    // Restarting an empty scan: one done pulse per two cycles,
                    // the same pace as a scan that emits words.
                    done_d = !done;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (at_last) begin
                        done_d = 1'b1;
                        if (AUTO_RESTART) begin
                            sel_d   = first_slot;
                            state_d = ST_SEL;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sel_d   = next_slot;
                        state_d = ST_SEL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and over an accept in the same cycle.
        if (abort) begin
            state_d     = ST_IDLE;
            sel_d       = sel;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule
